// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibit, request-to-send,
// shift a command byte out on the device clock, then check ACK.
module ps2_host_tx #(
   parameter int unsigned INHIBIT_CYCLES = 6000,
   parameter int unsigned START_TIMEOUT  = 750000,
   parameter int unsigned XFER_TIMEOUT   = 100000
) (
   input  logic       clk,
   input  logic       resetn,
   input  logic       send,
   input  logic [7:0] cmd,
   input  logic       ps2_clk_in,
   input  logic       ps2_dat_in,
   output logic       ps2_clk_oe,
   output logic       ps2_dat_oe,
   output logic       busy,
   output logic       done,
   output logic       error
);

   typedef enum logic [2:0] {
      S_IDLE, S_INHIBIT, S_REQUEST, S_SHIFT,
      S_ACK, S_WAIT_IDLE, S_DONE, S_ERROR
   } state_t;

   localparam logic [19:0] INH_LAST = 20'(INHIBIT_CYCLES - 1);
   localparam logic [19:0] STA_LAST = 20'(START_TIMEOUT - 1);
   localparam logic [19:0] XFR_LAST = 20'(XFER_TIMEOUT - 1);

   state_t      state_q, state_d;
   logic [19:0] timer_q, timer_d;
   logic [19:0] xfer_q, xfer_d;
   logic [3:0]  idx_q, idx_d;
   logic [7:0]  cmd_q, cmd_d;
   logic        par_q, par_d;
   logic        clk_s1_q, clk_s2_q, clk_p_q;
   logic        dat_s1_q, dat_s2_q;
   logic        fall, frame_bit, xfer_exp;

   // Idle-high line levels, so reset presets the synchronizers to 1.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         clk_s1_q <= 1'b1;
         clk_s2_q <= 1'b1;
         clk_p_q  <= 1'b1;
         dat_s1_q <= 1'b1;
         dat_s2_q <= 1'b1;
      end else begin
         clk_s1_q <= ps2_clk_in;
         clk_s2_q <= clk_s1_q;
         clk_p_q  <= clk_s2_q;
         dat_s1_q <= ps2_dat_in;
         dat_s2_q <= dat_s1_q;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q <= S_IDLE;
         timer_q <= '0;
         xfer_q  <= '0;
         idx_q   <= '0;
         cmd_q   <= '0;
         par_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         timer_q <= timer_d;
         xfer_q  <= xfer_d;
         idx_q   <= idx_d;
         cmd_q   <= cmd_d;
         par_q   <= par_d;
      end
   end

   assign fall     = clk_p_q & ~clk_s2_q;
   assign xfer_exp = (xfer_q == XFR_LAST);

   always_comb begin
      frame_bit = 1'b1;
      if (idx_q < 4'd8)
         frame_bit = cmd_q[idx_q[2:0]];
      else if (idx_q == 4'd8)
         frame_bit = par_q;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE:
            if (send) state_d = S_INHIBIT;
         S_INHIBIT:
            if (timer_q == INH_LAST) state_d = S_REQUEST;
         S_REQUEST:
            if (fall)                     state_d = S_SHIFT;
            else if (timer_q == STA_LAST) state_d = S_ERROR;
         // Stop is driven for one cycle, then ACK waits on the next edge.
         S_SHIFT:
            if (idx_q == 4'd9)  state_d = S_ACK;
            else if (!fall && xfer_exp) state_d = S_ERROR;
         S_ACK:
            if (fall)          state_d = dat_s2_q ? S_ERROR : S_WAIT_IDLE;
            else if (xfer_exp) state_d = S_ERROR;
         S_WAIT_IDLE:
            if (clk_s2_q && dat_s2_q)     state_d = S_DONE;
            else if (timer_q == XFR_LAST) state_d = S_ERROR;
         S_DONE:  state_d = S_IDLE;
         S_ERROR: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      timer_d = (timer_q == '1) ? timer_q : timer_q + 20'd1;
      if (state_d != state_q) timer_d = '0;
      xfer_d = '0;
      if (state_q == S_SHIFT || state_q == S_ACK)
         xfer_d = (xfer_q == '1) ? xfer_q : xfer_q + 20'd1;
      idx_d = idx_q;
      cmd_d = cmd_q;
      par_d = par_q;
      if (state_q == S_IDLE && send) begin
         cmd_d = cmd;
         par_d = ~^cmd;
      end
      if (state_q == S_REQUEST && fall) idx_d = '0;
      if (state_q == S_SHIFT && fall && idx_q < 4'd9)
         idx_d = idx_q + 4'd1;
   end

   always_comb begin
      ps2_clk_oe = 1'b0;
      ps2_dat_oe = 1'b0;
      busy       = (state_q != S_IDLE);
      done       = 1'b0;
      error      = 1'b0;
      unique case (state_q)
         S_INHIBIT: begin
            ps2_clk_oe = 1'b1;
            ps2_dat_oe = (timer_q == INH_LAST);
         end
         S_REQUEST: ps2_dat_oe = 1'b1;
         S_SHIFT:   ps2_dat_oe = ~frame_bit;
         S_DONE:    done = 1'b1;
         S_ERROR:   error = 1'b1;
         default: ;
      endcase
   end

endmodule

// File: doc/ps2_host_tx.md
PS2_HOST_TX -- requirements
Module: ps2_host_tx

Interface
REQ-001 SHALL have parameter INHIBIT_CYCLES, default 6000: clk cycles the PS/2 clock is held low before a request (120 us at 50 MHz).
REQ-002 SHALL have parameter START_TIMEOUT, default 750000: max cycles from clock release to the device's first falling edge (15 ms).
REQ-003 SHALL have parameter XFER_TIMEOUT, default 100000: max cycles from the first falling edge to the ACK edge (2 ms).
REQ-004 clk  input  1  system clock, 50 MHz; one clock; all state on its rising edge.
REQ-005 resetn  input  1  asynchronous, active-low reset.
REQ-006 send  input  1  one-cycle request to transmit cmd.
REQ-007 cmd  input  8  command byte; sampled only when send is accepted.
REQ-008 ps2_clk_in  input  1  raw PS2_CLK pad level.
REQ-009 ps2_dat_in  input  1  raw PS2_DAT pad level.
REQ-010 ps2_clk_oe  output  1  1 = drive PS2_CLK low; 0 = release (high-Z, pulled up).
REQ-011 ps2_dat_oe  output  1  1 = drive PS2_DAT low; 0 = release.
REQ-012 busy  output  1  high from send acceptance until the done or error pulse, inclusive.
REQ-013 done  output  1  one-cycle pulse: byte sent and ACK received.
REQ-014 error  output  1  one-cycle pulse: timeout or missing ACK.

Function
REQ-015 ps2_clk_in and ps2_dat_in SHALL each pass through a 2-flop synchronizer.
REQ-016 A PS/2 falling edge SHALL be detected when the synchronized clock is 1 in one cycle and 0 in the next.
REQ-017 States SHALL be IDLE, INHIBIT, REQUEST, SHIFT, ACK, WAIT_IDLE, DONE, ERROR.
REQ-018 IDLE: send=1 SHALL latch cmd, compute odd parity (parity = ~^cmd), clear the timer, and move to INHIBIT; busy rises the next cycle.
REQ-019 send while busy=1 SHALL be ignored; the latched byte SHALL NOT change.
REQ-020 INHIBIT SHALL assert ps2_clk_oe=1 for INHIBIT_CYCLES cycles.
REQ-021 In the last INHIBIT cycle, ps2_dat_oe SHALL become 1 (start bit 0).
REQ-022 INHIBIT SHALL then move to REQUEST with ps2_clk_oe=0.
REQ-023 REQUEST SHALL hold ps2_dat_oe=1 until the first falling edge, then move to SHIFT with bit index 0.
REQ-024 REQUEST SHALL go to ERROR if no edge arrives within START_TIMEOUT cycles.
REQ-025 SHIFT SHALL drive frame bit k on the falling edge following its entry: k=0..7 are data bits LSB first, k=8 is parity, k=9 is stop.
REQ-026 A frame bit of 1 SHALL set ps2_dat_oe=0; a bit of 0 SHALL set ps2_dat_oe=1.
REQ-027 Each bit SHALL be updated in the cycle after the falling edge is detected.
REQ-028 After driving stop (ps2_dat_oe=0), SHIFT SHALL move to ACK.
REQ-029 ACK: on the next falling edge, synchronized dat=0 SHALL move to WAIT_IDLE; dat=1 SHALL move to ERROR.
REQ-030 XFER_TIMEOUT SHALL be counted from the first falling edge through ACK; expiry SHALL move to ERROR.
REQ-031 WAIT_IDLE SHALL wait until synchronized clk and dat are both 1, then move to DONE.
REQ-032 WAIT_IDLE SHALL go to ERROR after XFER_TIMEOUT cycles in that state.
REQ-033 DONE and ERROR SHALL each last one cycle, pulse done or error respectively, and return to IDLE.
REQ-034 done and error SHALL never be asserted in the same cycle.
REQ-035 Outside INHIBIT, REQUEST and SHIFT, both oe outputs SHALL be 0; ERROR SHALL release both lines.
REQ-036 The timer SHALL be 20 bits, saturating, and cleared on every state change.
REQ-037 The bit index SHALL be 4 bits and SHALL NOT wrap past 9.

Reset
REQ-038 resetn=0 SHALL immediately force state=IDLE.
REQ-039 resetn=0 SHALL clear ps2_clk_oe, ps2_dat_oe, busy, done, error, the timer, the bit index and the latched byte to 0, and preset both synchronizers to 1.
REQ-040 Reset mid-transfer SHALL release both lines within the same cycle and SHALL NOT produce done or error.

Verification
REQ-041 send, cmd=8'hED, device model clocks at 12.5 kHz and ACKs -> clk held low 6000 cycles; line bits 0,1,0,1,1,0,1,1,1 (parity=1), stop=1; one done pulse; busy falls with it.
REQ-042 cmd=8'hF4 -> data LSB-first 0,0,1,0,1,1,1,1, parity=0; done pulse.
REQ-043 cmd=8'hFF, device never clocks -> error pulse exactly START_TIMEOUT cycles after clock release; both oe=0.
REQ-044 cmd=8'hFF, device leaves dat=1 on the 11th falling edge -> error pulse; no done.
REQ-045 Second send during the transfer of 8'hED -> ignored; 8'hED sent intact.
REQ-046 resetn pulsed low during bit 4 -> oe outputs=0 asynchronously; no done or error; next send of 8'hF4 completes normally.
